// File: rtl/hex_disp_pkg.sv
// Shared constants for the seven-segment display path: segment width,
// the active-low blank pattern and the 16 hexadecimal glyph codes.
package hex_disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit0 = segment a .. bit6 = segment g
    localparam logic [SEG_W-1:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_encode
    import hex_disp_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table lookup of the glyph for one hexadecimal digit
    always_comb begin
        seg_o = SEG_CODES[nibble_i];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: value capture with acknowledge,
// leading-zero blanking, per-digit enables and a blink timer, registered HEX.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Load,
    input  logic [4*N_DIGITS-1:0]     Value,
    input  logic                      BlankEn,
    input  logic                      BlinkEn,
    input  logic [N_DIGITS-1:0]       DigitEn,
    output logic                      LoadAck,
    output logic                      BlinkPhase,
    output logic [SEG_W*N_DIGITS-1:0] HEX
);

    localparam int VAL_W = 4 * N_DIGITS;
    localparam int HEX_W = SEG_W * N_DIGITS;
    // Keep at least one counter bit so BLINK_DIV = 1 still elaborates
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [VAL_W-1:0]  value_d, value_q;
    logic              ack_d, ack_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              phase_d, phase_q;
    logic [HEX_W-1:0]  hex_d, hex_q;

    logic [N_DIGITS-1:0] keep_s;
    logic                seen_s;
    logic                blank_all_s;
    logic [SEG_W-1:0]    seg_s [N_DIGITS];

    // One glyph encoder per digit, fed from the stored value
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .nibble_i (value_q[4*g +: 4]),
            .seg_o    (seg_s[g])
        );
    end

    // Value capture, acknowledge and blink timer next-state
    always_comb begin
        value_d = value_q;
        ack_d   = 1'b0;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (Load) begin
            // Restart the blink cycle so a fresh value gets a full visible half
            value_d = Value;
            ack_d   = 1'b1;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (!BlinkEn) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Mark digits at or below the most significant nonzero nibble; digit 0 always kept
    always_comb begin
        seen_s = 1'b0;
        keep_s = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                seen_s = 1'b1;
            end else begin
                seen_s = seen_s;
            end
            keep_s[i] = seen_s || (i == 0);
        end
    end

    // Per-digit segment selection with blink, enable and leading-zero blanking
    always_comb begin
        hex_d       = '1;
        blank_all_s = BlinkEn && phase_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (blank_all_s || !DigitEn[i] || (BlankEn && !keep_s[i])) begin
                hex_d[SEG_W*i +: SEG_W] = SEG_BLANK;
            end else begin
                hex_d[SEG_W*i +: SEG_W] = seg_s[i];
            end
        end
    end

    // State registers; reset wins over a simultaneous load
    always_ff @(posedge Clock) begin
        if (Reset) begin
            value_q <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            hex_q   <= '1;
        end else begin
            value_q <= value_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
        end
    end

    assign LoadAck    = ack_q;
    assign BlinkPhase = phase_q;
    assign HEX        = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with N_DIGITS=6 and BLINK_DIV=4.
module tb_hex_display_ctrl;

    localparam logic [41:0] H_BLANK    = {6{7'h7F}};
    localparam logic [41:0] H_ZERO_LZ  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [41:0] H_ZERO_ALL = {6{7'h40}};
    localparam logic [41:0] H_C0DE_LZ  = {7'h7F, 7'h7F, 7'h46, 7'h40, 7'h21, 7'h06};
    localparam logic [41:0] H_C0DE_EN  = {7'h40, 7'h40, 7'h46, 7'h40, 7'h21, 7'h7F};
    localparam logic [41:0] H_123456   = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
    localparam logic [41:0] H_ABCDEF   = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [41:0] H_789012   = {7'h78, 7'h00, 7'h10, 7'h40, 7'h79, 7'h24};

    logic        Clock;
    logic        Reset;
    logic        Load;
    logic [23:0] Value;
    logic        BlankEn;
    logic        BlinkEn;
    logic [5:0]  DigitEn;
    logic        LoadAck;
    logic        BlinkPhase;
    logic [41:0] HEX;

    int n_assert = 0;
    int n_fail   = 0;

    hex_display_ctrl #(
        .N_DIGITS  (6),
        .BLINK_DIV (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Load       (Load),
        .Value      (Value),
        .BlankEn    (BlankEn),
        .BlinkEn    (BlinkEn),
        .DigitEn    (DigitEn),
        .LoadAck    (LoadAck),
        .BlinkPhase (BlinkPhase),
        .HEX        (HEX)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        Load    = 1'b0;
        Value   = 24'h000000;
        BlankEn = 1'b0;
        BlinkEn = 1'b0;
        DigitEn = 6'h00;

        tick();
        check("reset_hex", HEX, H_BLANK);
        check("reset_ack", {41'd0, LoadAck}, 42'd0);
        check("reset_phase", {41'd0, BlinkPhase}, 42'd0);

        Reset   = 1'b0;
        BlankEn = 1'b1;
        DigitEn = 6'h3F;
        tick();
        check("zero_lz", HEX, H_ZERO_LZ);

        Load  = 1'b1;
        Value = 24'h00C0DE;
        tick();
        Load = 1'b0;
        check("c0de_ack", {41'd0, LoadAck}, 42'd1);
        check("c0de_hex_old", HEX, H_ZERO_LZ);
        tick();
        check("c0de_ack_end", {41'd0, LoadAck}, 42'd0);
        check("c0de_lz", HEX, H_C0DE_LZ);

        BlankEn = 1'b0;
        DigitEn = 6'b111110;
        tick();
        check("c0de_digen", HEX, H_C0DE_EN);

        BlankEn = 1'b1;
        DigitEn = 6'h3F;
        Load    = 1'b1;
        Value   = 24'h123456;
        tick();
        check("b2b_ack0", {41'd0, LoadAck}, 42'd1);
        tick();
        check("b2b_ack1", {41'd0, LoadAck}, 42'd1);
        Load = 1'b0;
        tick();
        check("b2b_ack_end", {41'd0, LoadAck}, 42'd0);
        check("val_123456", HEX, H_123456);

        BlinkEn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("blink_hex_%0d", k), HEX,
                  (((k / 4) % 2) == 1) ? H_BLANK : H_123456);
            check($sformatf("blink_phase_%0d", k), {41'd0, BlinkPhase},
                  {41'd0, ((((k + 1) / 4) % 2) == 1)});
        end
        tick();
        check("blanked_hex", HEX, H_BLANK);
        check("blanked_phase", {41'd0, BlinkPhase}, 42'd1);

        Load  = 1'b1;
        Value = 24'h00C0DE;
        tick();
        Load = 1'b0;
        check("reload_ack", {41'd0, LoadAck}, 42'd1);
        check("reload_phase", {41'd0, BlinkPhase}, 42'd0);
        check("reload_hex_old", HEX, H_BLANK);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check($sformatf("reload_vis_%0d", j), HEX, H_C0DE_LZ);
            check($sformatf("reload_phase_%0d", j), {41'd0, BlinkPhase},
                  {41'd0, (j == 4)});
        end
        tick();
        check("reload_blank", HEX, H_BLANK);

        BlinkEn = 1'b0;
        BlankEn = 1'b0;
        Load    = 1'b1;
        Value   = 24'hABCDEF;
        tick();
        Load = 1'b0;
        check("blink_off_phase", {41'd0, BlinkPhase}, 42'd0);
        tick();
        check("val_abcdef", HEX, H_ABCDEF);

        Load  = 1'b1;
        Value = 24'h789012;
        tick();
        Load = 1'b0;
        tick();
        check("val_789012", HEX, H_789012);

        BlinkEn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        check("pre_reset_phase", {41'd0, BlinkPhase}, 42'd1);

        Reset = 1'b1;
        Load  = 1'b1;
        Value = 24'hFFFFFF;
        tick();
        check("rst_load_ack", {41'd0, LoadAck}, 42'd0);
        check("rst_load_hex", HEX, H_BLANK);
        check("rst_load_phase", {41'd0, BlinkPhase}, 42'd0);

        Reset   = 1'b0;
        Load    = 1'b0;
        BlinkEn = 1'b0;
        DigitEn = 6'h3F;
        tick();
        check("rst_stored_zero", HEX, H_ZERO_ALL);
        check("rst_ack_after", {41'd0, LoadAck}, 42'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 6, giving the number of seven-segment digits (legal 1..8).
REQ-002 The block SHALL have parameter BLINK_DIV, default 25_000_000, giving the blink half-period in Clock cycles (legal >= 1).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Load, input, 1 bit: capture strobe for Value.
REQ-006 The block SHALL have port Value, input, 4*N_DIGITS bits: nibble i maps to digit i (digit 0 least significant).
REQ-007 The block SHALL have port BlankEn, input, 1 bit: leading-zero blanking enable.
REQ-008 The block SHALL have port BlinkEn, input, 1 bit: blink mode enable.
REQ-009 The block SHALL have port DigitEn, input, N_DIGITS bits: per-digit enable; 0 forces that digit blank.
REQ-010 The block SHALL have port LoadAck, output, 1 bit: one-cycle pulse confirming a capture.
REQ-011 The block SHALL have port BlinkPhase, output, 1 bit: current blink phase (1 = blanked half).
REQ-012 The block SHALL have port HEX, output, 7*N_DIGITS bits: active-low segments; HEX[7i+6:7i] drives digit i, bit0=a through bit6=g.

Function
REQ-013 At a rising edge with Load=1, the block SHALL capture Value into the internal value register.
REQ-014 LoadAck SHALL be 1 for exactly the one cycle following each capturing edge; back-to-back Load SHALL give back-to-back pulses.
REQ-015 HEX SHALL be registered, and a captured value SHALL appear on HEX at the edge after the capturing edge (latency 2 edges from Load sampled).
REQ-016 Nibble encoding SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex); blank SHALL be 7F.
REQ-017 With BlankEn=1, every digit above the most significant nonzero nibble SHALL be blank; digit 0 SHALL never be blanked by this rule.
REQ-018 A digit with DigitEn[i]=0 SHALL be blank regardless of value; DigitEn, BlankEn and BlinkEn SHALL take effect at the next edge.
REQ-019 The blink counter SHALL count 0..BLINK_DIV-1 and wrap; BlinkPhase SHALL toggle on each wrap; BLINK_DIV=1 SHALL toggle every cycle.
REQ-020 With BlinkEn=0, the counter and BlinkPhase SHALL be held at 0.
REQ-021 With BlinkEn=1 and BlinkPhase=1, all digits SHALL be blank; DigitEn and blanking rules SHALL apply otherwise.
REQ-022 A capturing Load SHALL clear the counter and BlinkPhase to 0 so the new value is visible for a full half-period.
REQ-023 Reset SHALL take priority over Load when both are 1 at the same edge.

Reset
REQ-024 At an edge with Reset=1, the value register, counter, BlinkPhase and LoadAck SHALL become 0, and HEX SHALL become all ones (all digits blank).
REQ-025 At the first edge after Reset deasserts, HEX SHALL show the stored zero under the current BlankEn/DigitEn/BlinkEn settings.
REQ-026 A Reset asserted mid-blink or during LoadAck SHALL abort both at that edge.

Structure
REQ-027 A shared package hex_disp_pkg SHALL hold the 16 segment codes, the blank code 7'h7F and the segment width constant 7.
REQ-028 The block SHALL instantiate N_DIGITS copies of the combinational sub-module seg7_encode (4-bit nibble in, 7-bit active-low segments out), built with a generate loop.

Verification
REQ-029 The bench SHALL cover N_DIGITS=6, BLINK_DIV=4: Reset 1 cycle -> HEX=all 7F; then BlankEn=1, DigitEn=3F -> digit0=40, digits1-5=7F.
REQ-030 The bench SHALL cover Load with Value=24'h00C0DE, BlankEn=1 -> LoadAck pulse next cycle; HEX then digit3..0 = 46,40,21,06, and digits 5,4 = 7F.
REQ-031 The bench SHALL cover the same value with BlankEn=0, DigitEn=6'b111110 -> digit0=7F, digits5,4=40.
REQ-032 The bench SHALL cover BlinkEn=1 with value 24'h123456 -> 4 cycles visible, then 4 cycles all 7F, repeating; BlinkPhase tracks it.
REQ-033 The bench SHALL cover a Load during the blanked phase -> BlinkPhase=0 next cycle and the new value visible for 4 cycles.
REQ-034 The bench SHALL cover Reset and Load both high -> LoadAck stays 0, HEX=all 7F, and the stored value is 0.
